// File: rtl/gp_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : gp_reg_bank
// Description : Parameterised bank of RW / RO / W1C registers with a
//               strobe-based access port, registered readback and error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module gp_reg_bank #(
    parameter int                  bus_width  = 15,
    parameter int                  num_regs   = 8,
    parameter int                  addr_width = 3,
    parameter logic [bus_width:0]  reset_val  = '0,
    parameter logic [num_regs-1:0] ro_mask    = '0,
    parameter logic [num_regs-1:0] w1c_mask   = '0
) (
    input  logic                              sysclk,
    input  logic                              reset,
    input  logic                              wrb,
    input  logic                              rdb,
    input  logic [addr_width-1:0]             addr,
    input  logic [bus_width:0]                din,
    input  logic [num_regs*(bus_width+1)-1:0] hw_in,
    input  logic [num_regs*(bus_width+1)-1:0] hw_set,
    output logic [bus_width:0]                rdout,
    output logic                              rd_valid,
    output logic                              err,
    output logic [num_regs*(bus_width+1)-1:0] reg_out,
    output logic [num_regs-1:0]               wr_pulse
);

    localparam int                  c_W        = bus_width + 1;
    localparam logic [addr_width:0] c_NUM_REGS = (addr_width + 1)'(num_regs);

    logic                           w_wr;
    logic                           w_rd;
    logic                           w_legal;
    logic                           w_ro_wr;
    logic [num_regs-1:0]            w_sel;
    logic [num_regs-1:0]            w_wr_acc;
    logic [num_regs-1:0][c_W-1:0]   w_hw_in;
    logic [num_regs-1:0][c_W-1:0]   w_hw_set;
    logic [num_regs-1:0][c_W-1:0]   w_reg_view;
    logic [num_regs-1:0][c_W-1:0]   w_rd_val;
    logic [c_W-1:0]                 w_rd_data;

    logic [c_W-1:0]                 r_rdout;
    logic                           r_rd_valid;
    logic                           r_err;
    logic [num_regs-1:0]            r_wr_pulse;

    assign w_wr     = ~wrb;
    assign w_rd     = ~rdb;
    assign w_legal  = ({1'b0, addr} < c_NUM_REGS);
    assign w_hw_in  = hw_in;
    assign w_hw_set = hw_set;

    genvar i;
    generate
        for (i = 0; i < num_regs; i++) begin : g_reg
            assign w_sel[i] = w_legal && (addr == addr_width'(i));

            if (ro_mask[i]) begin : g_ro
                // Read-only: no storage, readback is the live hardware value.
                logic w_unused_set;
                assign w_unused_set  = ^w_hw_set[i];
                assign w_wr_acc[i]   = 1'b0;
                assign w_reg_view[i] = '0;
                assign w_rd_val[i]   = w_hw_in[i];
            end else if (w1c_mask[i]) begin : g_w1c
                logic [c_W-1:0] r_val;
                logic           w_unused_in;
                assign w_unused_in = ^w_hw_in[i];

                // Set is OR-ed after the clear so a simultaneous set wins.
                always_ff @(posedge sysclk) begin
                    if (reset) begin
                        r_val <= '0;
                    end else begin
                        r_val <= (r_val & ~((w_wr && w_sel[i]) ? din : '0)) | w_hw_set[i];
                    end
                end

                assign w_wr_acc[i]   = w_wr & w_sel[i];
                assign w_reg_view[i] = r_val;
                assign w_rd_val[i]   = r_val;
            end else begin : g_rw
                logic [c_W-1:0] r_val;
                logic           w_unused_in;
                assign w_unused_in = ^{w_hw_in[i], w_hw_set[i]};

                always_ff @(posedge sysclk) begin
                    if (reset) begin
                        r_val <= reset_val;
                    end else if (w_wr && w_sel[i]) begin
                        r_val <= din;
                    end
                end

                assign w_wr_acc[i]   = w_wr & w_sel[i];
                assign w_reg_view[i] = r_val;
                assign w_rd_val[i]   = r_val;
            end
        end
    endgenerate

    // Out-of-range addresses select nothing, so the mux yields zero.
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < num_regs; k++) begin
            if (w_sel[k]) begin
                w_rd_data = w_rd_val[k];
            end
        end
    end

    assign w_ro_wr = w_wr & (|(w_sel & ro_mask));

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_rdout    <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_wr_pulse <= '0;
        end else begin
            r_rd_valid <= w_rd;
            r_err      <= ((w_wr | w_rd) & ~w_legal) | w_ro_wr;
            r_wr_pulse <= w_wr_acc;
            if (w_rd) begin
                r_rdout <= w_rd_data;
            end
        end
    end

    assign rdout    = r_rdout;
    assign rd_valid = r_rd_valid;
    assign err      = r_err;
    assign wr_pulse = r_wr_pulse;
    assign reg_out  = w_reg_view;

endmodule
`default_nettype wire

// File: tb/tb_gp_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_gp_reg_bank
// Description : Directed self-checking bench for gp_reg_bank (5 regs,
//               reg1 RO, reg3 W1C, reset value 0xA5A5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gp_reg_bank;

    localparam int c_BW = 15;
    localparam int c_N  = 5;
    localparam int c_AW = 3;
    localparam int c_W  = c_BW + 1;

    logic                 sysclk = 1'b0;
    logic                 reset;
    logic                 wrb;
    logic                 rdb;
    logic [c_AW-1:0]      addr;
    logic [c_BW:0]        din;
    logic [c_N*c_W-1:0]   hw_in;
    logic [c_N*c_W-1:0]   hw_set;
    logic [c_BW:0]        rdout;
    logic                 rd_valid;
    logic                 err;
    logic [c_N*c_W-1:0]   reg_out;
    logic [c_N-1:0]       wr_pulse;

    int n_vec  = 0;
    int n_miss = 0;

    gp_reg_bank #(
        .bus_width  (c_BW),
        .num_regs   (c_N),
        .addr_width (c_AW),
        .reset_val  (16'hA5A5),
        .ro_mask    (5'h02),
        .w1c_mask   (5'h08)
    ) u_dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .wrb      (wrb),
        .rdb      (rdb),
        .addr     (addr),
        .din      (din),
        .hw_in    (hw_in),
        .hw_set   (hw_set),
        .rdout    (rdout),
        .rd_valid (rd_valid),
        .err      (err),
        .reg_out  (reg_out),
        .wr_pulse (wr_pulse)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    function automatic logic [c_BW:0] slice(input int idx);
        return reg_out[idx*c_W +: c_W];
    endfunction

    task automatic idle();
        wrb    = 1'b1;
        rdb    = 1'b1;
        addr   = '0;
        din    = '0;
        hw_set = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        hw_in = '0;
        hw_in[1*c_W +: c_W] = 16'hBEEF;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_reg_out", 80'(reg_out), {16'hA5A5, 16'h0000, 16'hA5A5, 16'h0000, 16'hA5A5});
        chk("rst_rd_valid", 80'(rd_valid), 80'(0));
        chk("rst_err", 80'(err), 80'(0));
        chk("rst_wr_pulse", 80'(wr_pulse), 80'(0));
        chk("rst_rdout", 80'(rdout), 80'(0));

        // RW write then read
        wrb = 1'b0; addr = 3'd2; din = 16'h1234;
        tick(); idle();
        chk("rw_wr_pulse", 80'(wr_pulse), 80'(5'b00100));
        chk("rw_reg2", 80'(slice(2)), 80'(16'h1234));
        chk("rw_err", 80'(err), 80'(0));
        rdb = 1'b0; addr = 3'd2;
        tick(); idle();
        chk("rw_wr_pulse_off", 80'(wr_pulse), 80'(0));
        chk("rw_rd_valid", 80'(rd_valid), 80'(1));
        chk("rw_rdout", 80'(rdout), 80'(16'h1234));
        tick();
        chk("rd_valid_drop", 80'(rd_valid), 80'(0));
        chk("rdout_hold", 80'(rdout), 80'(16'h1234));

        // RO write is rejected, read returns live hw_in
        wrb = 1'b0; addr = 3'd1; din = 16'h5555;
        tick(); idle();
        chk("ro_err", 80'(err), 80'(1));
        chk("ro_wr_pulse", 80'(wr_pulse), 80'(0));
        chk("ro_reg1", 80'(slice(1)), 80'(0));
        rdb = 1'b0; addr = 3'd1;
        tick(); idle();
        chk("ro_err_drop", 80'(err), 80'(0));
        chk("ro_rdout", 80'(rdout), 80'(16'hBEEF));

        // W1C set, then clear with concurrent set
        hw_set[3*c_W +: c_W] = 16'h000F;
        tick(); idle();
        chk("w1c_set", 80'(slice(3)), 80'(16'h000F));
        chk("w1c_set_no_pulse", 80'(wr_pulse), 80'(0));
        wrb = 1'b0; addr = 3'd3; din = 16'h0003;
        hw_set[3*c_W +: c_W] = 16'h0001;
        tick(); idle();
        chk("w1c_clear", 80'(slice(3)), 80'(16'h000D));
        chk("w1c_wr_pulse", 80'(wr_pulse), 80'(5'b01000));

        // Reset overrides a concurrent write and read
        wrb = 1'b0; addr = 3'd0; din = 16'h7777;
        tick(); idle();
        chk("pre_rst_reg0", 80'(slice(0)), 80'(16'h7777));
        reset = 1'b1; wrb = 1'b0; rdb = 1'b0; addr = 3'd0; din = 16'h0001;
        tick(); idle(); reset = 1'b0;
        chk("rst_ovr_reg_out", 80'(reg_out), {16'hA5A5, 16'h0000, 16'hA5A5, 16'h0000, 16'hA5A5});
        chk("rst_ovr_wr_pulse", 80'(wr_pulse), 80'(0));
        chk("rst_ovr_rd_valid", 80'(rd_valid), 80'(0));

        // Load reg4 and read it so rdout is non-zero
        wrb = 1'b0; addr = 3'd4; din = 16'h1111;
        tick(); idle();
        rdb = 1'b0; addr = 3'd4;
        tick(); idle();
        chk("reg4_rdout", 80'(rdout), 80'(16'h1111));

        // Illegal read and write
        rdb = 1'b0; addr = 3'd6;
        tick(); idle();
        chk("ill_rd_err", 80'(err), 80'(1));
        chk("ill_rd_valid", 80'(rd_valid), 80'(1));
        chk("ill_rd_rdout", 80'(rdout), 80'(0));
        wrb = 1'b0; addr = 3'd7; din = 16'hFFFF;
        tick(); idle();
        chk("ill_wr_err", 80'(err), 80'(1));
        chk("ill_wr_pulse", 80'(wr_pulse), 80'(0));
        chk("ill_reg_out", 80'(reg_out), {16'h1111, 16'h0000, 16'hA5A5, 16'h0000, 16'hA5A5});

        // Back-to-back reads
        rdb = 1'b0; addr = 3'd0;
        tick();
        chk("b2b_valid0", 80'(rd_valid), 80'(1));
        chk("b2b_rdout0", 80'(rdout), 80'(16'hA5A5));
        addr = 3'd4;
        tick(); idle();
        chk("b2b_valid1", 80'(rd_valid), 80'(1));
        chk("b2b_rdout1", 80'(rdout), 80'(16'h1111));

        // Simultaneous write and read: read-before-write
        wrb = 1'b0; rdb = 1'b0; addr = 3'd4; din = 16'h00FF;
        tick(); idle();
        chk("sim_rdout", 80'(rdout), 80'(16'h1111));
        chk("sim_wr_pulse", 80'(wr_pulse), 80'(5'b10000));
        chk("sim_reg4", 80'(slice(4)), 80'(16'h00FF));
        rdb = 1'b0; addr = 3'd4;
        tick(); idle();
        chk("sim_next_rdout", 80'(rdout), 80'(16'h00FF));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
